// File: rtl/regbank_mp_if.sv
// Register bank bus: two read ports, two write lanes, scoreboard mark and flush control.
interface regbank_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_pend_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_pend_b;

  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;

  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;

  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_pend_a, rd_data_b, rd_pend_b,
    output we0, wa0, wd0, we1, wa1, wd1,
    output mark_en, mark_addr,
    output clr_req,
    input  clr_busy, clr_done
  );

  modport slave (
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_pend_a, rd_data_b, rd_pend_b,
    input  we0, wa0, wd0, we1, wa1, wd1,
    input  mark_en, mark_addr,
    input  clr_req,
    output clr_busy, clr_done
  );
endinterface

// File: rtl/regbank_mp.sv
// 2R/2W register bank with per-register pending bits and a one-entry-per-cycle flush sweep.
// Optional same-cycle write-to-read forwarding when REGBANK_BYPASS_EN is defined.
module regbank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regbank_mp_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;

  logic idle;
  logic wr0_ok;
  logic wr1_ok;
  logic mark_ok;

  // Writes and marks only take effect while idle; flush owns the file otherwise.
  assign idle    = (state == ST_IDLE);
  assign wr0_ok  = idle && bus.we0     && !(ZERO_REG && (bus.wa0 == '0));
  assign wr1_ok  = idle && bus.we1     && !(ZERO_REG && (bus.wa1 == '0));
  assign mark_ok = idle && bus.mark_en && !(ZERO_REG && (bus.mark_addr == '0));

  assign bus.clr_busy = (state == ST_SWEEP);
  assign bus.clr_done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state <= ST_SWEEP;
            cnt   <= '0;
          end
        end
        ST_SWEEP: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane 1 assigned after lane 0 so it wins a same-index collision; mark last so it wins over writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pend <= '0;
    end else if (state == ST_SWEEP) begin
      regs[cnt] <= '0;
      pend[cnt] <= 1'b0;
    end else begin
      if (wr0_ok) begin
        regs[bus.wa0] <= bus.wd0;
        pend[bus.wa0] <= 1'b0;
      end
      if (wr1_ok) begin
        regs[bus.wa1] <= bus.wd1;
        pend[bus.wa1] <= 1'b0;
      end
      if (mark_ok) pend[bus.mark_addr] <= 1'b1;
    end
  end

  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] d;
    logic              p;
    d = regs[addr];
    p = pend[addr];
`ifdef REGBANK_BYPASS_EN
    // Forwarded reads report the pending bit as it will be after the edge.
    if (wr0_ok && (bus.wa0 == addr)) begin
      d = bus.wd0;
      p = mark_ok && (bus.mark_addr == addr);
    end
    if (wr1_ok && (bus.wa1 == addr)) begin
      d = bus.wd1;
      p = mark_ok && (bus.mark_addr == addr);
    end
`endif
    if (ZERO_REG && (addr == '0)) begin
      d = '0;
      p = 1'b0;
    end
    return {p, d};
  endfunction

  always_comb begin
    {bus.rd_pend_a, bus.rd_data_a} = lookup(bus.rd_addr_a);
    {bus.rd_pend_b, bus.rd_data_b} = lookup(bus.rd_addr_b);
  end
endmodule

// File: tb/tb_regbank_mp.sv
// Randomized self-checking bench for regbank_mp against an array-based reference model.
module tb_regbank_mp;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  regbank_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regbank_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 sweeping, 2 done; pos is the next entry to clear.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  int          m_phase;
  int          m_pos;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_phase = 0;
    m_pos   = 0;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      if (bus.we0 && bus.wa0 != 0) begin
        m_regs[bus.wa0] = bus.wd0;
        m_pend[bus.wa0] = 1'b0;
      end
      if (bus.we1 && bus.wa1 != 0) begin
        m_regs[bus.wa1] = bus.wd1;
        m_pend[bus.wa1] = 1'b0;
      end
      if (bus.mark_en && bus.mark_addr != 0) m_pend[bus.mark_addr] = 1'b1;
      if (bus.clr_req) begin
        m_phase = 1;
        m_pos   = 0;
      end
    end else if (m_phase == 1) begin
      m_regs[m_pos] = '0;
      m_pend[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == 32) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] d;
    d = m_regs[a];
`ifdef REGBANK_BYPASS_EN
    if (m_phase == 0 && a != 0) begin
      if (bus.we0 && bus.wa0 == a) d = bus.wd0;
      if (bus.we1 && bus.wa1 == a) d = bus.wd1;
    end
`endif
    return d;
  endfunction

  function automatic logic exp_pend(input logic [4:0] a);
    logic p;
    p = m_pend[a];
`ifdef REGBANK_BYPASS_EN
    if (m_phase == 0 && a != 0 &&
        ((bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a)))
      p = bus.mark_en && (bus.mark_addr == a);
`endif
    return p;
  endfunction

  task automatic idle_inputs();
    bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
    bus.mark_en = 1'b0; bus.mark_addr = '0;
    bus.clr_req = 1'b0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd31;
    rst_n = 1'b0;
    idle_inputs();
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    model_reset();
    #3;
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr_a = addrs[i];
      #1;
      checks++;
      if (bus.rd_data_a !== 32'h0) begin
        errors++; $display("FAIL reset_data[%0d]: got %h expected 00000000", addrs[i], bus.rd_data_a);
      end
      checks++;
      if (bus.rd_pend_a !== 1'b0) begin
        errors++; $display("FAIL reset_pend[%0d]: got %b expected 0", addrs[i], bus.rd_pend_a);
      end
    end
    checks++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      errors++; $display("FAIL reset_flush_flags: got busy=%b done=%b expected 0 0", bus.clr_busy, bus.clr_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
    bus.rd_addr_a = 5'd5;
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (bus.rd_data_a !== 32'hDEADBEEF) begin
      errors++; $display("FAIL first_write: got %h expected deadbeef", bus.rd_data_a);
    end
  endtask

  task automatic test_lane_conflict();
    bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11111111;
    bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22222222;
    cycle();
    idle_inputs();
    bus.rd_addr_b = 5'd7;
    #1;
    checks++;
    if (bus.rd_data_b !== 32'h22222222) begin
      errors++; $display("FAIL lane1_wins: got %h expected 22222222", bus.rd_data_b);
    end
    bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hFFFFFFFF;
    cycle();
    idle_inputs();
    bus.rd_addr_a = 5'd0;
    #1;
    checks++;
    if (bus.rd_data_a !== 32'h0) begin
      errors++; $display("FAIL zero_reg_write: got %h expected 00000000", bus.rd_data_a);
    end
  endtask

  task automatic test_pending();
    bus.rd_addr_a = 5'd9;
    bus.mark_en = 1'b1; bus.mark_addr = 5'd9;
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (bus.rd_pend_a !== 1'b1) begin
      errors++; $display("FAIL mark_sets: got %b expected 1", bus.rd_pend_a);
    end
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'hA5;
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (bus.rd_pend_a !== 1'b0) begin
      errors++; $display("FAIL write_clears: got %b expected 0", bus.rd_pend_a);
    end
    cycle();
    bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'hA5;
    bus.mark_en = 1'b1; bus.mark_addr = 5'd9;
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (bus.rd_pend_a !== 1'b1 || bus.rd_data_a !== 32'hA5) begin
      errors++; $display("FAIL mark_beats_write: got pend=%b data=%h expected 1 000000a5", bus.rd_pend_a, bus.rd_data_a);
    end
    bus.mark_en = 1'b1; bus.mark_addr = 5'd0;
    cycle();
    idle_inputs();
    bus.rd_addr_b = 5'd0;
    #1;
    checks++;
    if (bus.rd_pend_b !== 1'b0) begin
      errors++; $display("FAIL zero_reg_mark: got %b expected 0", bus.rd_pend_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.we0 = 1'($urandom_range(0, 1)); bus.wa0 = 5'($urandom); bus.wd0 = $urandom;
      bus.we1 = 1'($urandom_range(0, 1)); bus.wa1 = 5'($urandom); bus.wd1 = $urandom;
      bus.mark_en = 1'($urandom_range(0, 1)); bus.mark_addr = 5'($urandom);
      bus.clr_req = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) bus.rd_addr_a = bus.wa1;
      else bus.rd_addr_a = 5'($urandom);
      if ($urandom_range(0, 3) == 0) bus.rd_addr_b = bus.wa0;
      else bus.rd_addr_b = 5'($urandom);
      #1;
      checks++;
      if (bus.rd_data_a !== exp_data(bus.rd_addr_a) || bus.rd_pend_a !== exp_pend(bus.rd_addr_a)) begin
        errors++; $display("FAIL rand_port_a[%0d]: got %h/%b expected %h/%b", i, bus.rd_data_a, bus.rd_pend_a,
                           exp_data(bus.rd_addr_a), exp_pend(bus.rd_addr_a));
      end
      checks++;
      if (bus.rd_data_b !== exp_data(bus.rd_addr_b) || bus.rd_pend_b !== exp_pend(bus.rd_addr_b)) begin
        errors++; $display("FAIL rand_port_b[%0d]: got %h/%b expected %h/%b", i, bus.rd_data_b, bus.rd_pend_b,
                           exp_data(bus.rd_addr_b), exp_pend(bus.rd_addr_b));
      end
      checks++;
      if (bus.clr_busy !== (m_phase == 1) || bus.clr_done !== (m_phase == 2)) begin
        errors++; $display("FAIL rand_flags[%0d]: got busy=%b done=%b expected phase %0d", i, bus.clr_busy, bus.clr_done, m_phase);
      end
      cycle();
    end
    idle_inputs();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (m_phase != 0 && n < 40) begin
      cycle();
      n++;
    end
    checks++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      errors++; $display("FAIL %s_idle: got busy=%b done=%b expected 0 0", name, bus.clr_busy, bus.clr_done);
    end
  endtask

  task automatic fill_all();
    for (int k = 0; k < 16; k++) begin
      bus.we0 = 1'b1; bus.wa0 = 5'(2 * k);     bus.wd0 = $urandom | 32'h1;
      bus.we1 = 1'b1; bus.wa1 = 5'(2 * k + 1); bus.wd1 = $urandom | 32'h1;
      cycle();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int busy_cycles;
    int done_cycles;
    busy_cycles = 0;
    done_cycles = 0;
    wait_idle("flush_pre");
    fill_all();
    bus.rd_addr_a = 5'd31;
    #1;
    checks++;
    if (bus.rd_data_a === 32'h0) begin
      errors++; $display("FAIL fill: got %h expected nonzero", bus.rd_data_a);
    end
    bus.clr_req = 1'b1;
    cycle();
    idle_inputs();
    for (int i = 0; i < 40; i++) begin
      if (i < 20) begin
        bus.we0 = 1'b1; bus.wa0 = 5'd12; bus.wd0 = 32'hCAFE0000 + 32'(i);
        bus.mark_en = 1'b1; bus.mark_addr = 5'd20;
      end else begin
        bus.we0 = 1'b0; bus.mark_en = 1'b0;
      end
      bus.clr_req = (i == 5);
      #1;
      checks++;
      if (bus.clr_busy !== (m_phase == 1) || bus.clr_done !== (m_phase == 2)) begin
        errors++; $display("FAIL flush_flags[%0d]: got busy=%b done=%b expected phase %0d", i, bus.clr_busy, bus.clr_done, m_phase);
      end
      if (bus.clr_busy === 1'b1) busy_cycles++;
      if (bus.clr_done === 1'b1) done_cycles++;
      cycle();
    end
    idle_inputs();
    checks++;
    if (busy_cycles != 32) begin
      errors++; $display("FAIL busy_len: got %0d expected 32", busy_cycles);
    end
    checks++;
    if (done_cycles != 1) begin
      errors++; $display("FAIL done_len: got %0d expected 1", done_cycles);
    end
    for (int r = 0; r < 32; r++) begin
      bus.rd_addr_a = 5'(r);
      bus.rd_addr_b = 5'(31 - r);
      #1;
      checks++;
      if (bus.rd_data_a !== 32'h0 || bus.rd_pend_a !== 1'b0 || bus.rd_data_b !== 32'h0 || bus.rd_pend_b !== 1'b0) begin
        errors++; $display("FAIL flushed[%0d]: got a=%h/%b b=%h/%b expected zeros", r,
                           bus.rd_data_a, bus.rd_pend_a, bus.rd_data_b, bus.rd_pend_b);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    wait_idle("mid_pre");
    fill_all();
    bus.clr_req = 1'b1;
    cycle();
    idle_inputs();
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (bus.clr_busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b expected 1", bus.clr_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      errors++; $display("FAIL async_abort: got busy=%b done=%b expected 0 0", bus.clr_busy, bus.clr_done);
    end
    model_reset();
    bus.rd_addr_a = 5'd30;
    #1;
    checks++;
    if (bus.rd_data_a !== 32'h0) begin
      errors++; $display("FAIL abort_cleared: got %h expected 00000000", bus.rd_data_a);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
        errors++; $display("FAIL post_abort_idle[%0d]: got busy=%b done=%b expected 0 0", i, bus.clr_busy, bus.clr_done);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    wait_idle("bypass_pre");
    bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'hAAAA0000;
    cycle();
    idle_inputs();
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h12345678;
    bus.rd_addr_a = 5'd3;
    bus.rd_addr_b = 5'd3;
    #1;
`ifdef REGBANK_BYPASS_EN
    want = 32'h12345678;
`else
    want = 32'hAAAA0000;
`endif
    checks++;
    if (bus.rd_data_a !== want || bus.rd_data_b !== want) begin
      errors++; $display("FAIL same_cycle_read: got %h/%h expected %h", bus.rd_data_a, bus.rd_data_b, want);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (bus.rd_data_a !== 32'h12345678) begin
      errors++; $display("FAIL next_cycle_read: got %h expected 12345678", bus.rd_data_a);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lane_conflict();
    test_pending();
    test_random();
    test_flush();
    test_reset_mid_sweep();
    test_random();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
